symm_row_serializer: RTL and testbench

//  Read-side counterpart of the 4x4 matrix select register. Captures one 4x4 signed matrix with a

---
 rtl/fica_mat_pkg.sv | 7 +
 rtl/symm_row_mux.sv | 16 +
 rtl/symm_row_serializer.sv | 90 +++++++++
 tb/tb_symm_row_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fica_mat_pkg.sv
// fica_mat_pkg: shared widths, matrix order and serializer state encoding
package fica_mat_pkg;
  localparam int DW_MAT = 26;
  localparam int ROWS = 4;
  typedef enum logic [1:0] {IDLE, SEND, DONE} ser_state_t;
  typedef logic signed [0:ROWS-1][DW_MAT-1:0] mat_row_t;
endpackage

// File: rtl/symm_row_mux.sv
// symm_row_mux: picks row (or column when transposed) sel of a 4x4 matrix, m[4*(R-1)+(C-1)] = iRC
module symm_row_mux
  import fica_mat_pkg::*;
#(
  parameter int DW = DW_MAT
) (
  input  logic [15:0][DW-1:0] m,
  input  logic [1:0]          sel,
  input  logic                transpose,
  output logic [3:0][DW-1:0]  row
);
  for (genvar j = 0; j < 4; j++) begin : g_col
    localparam logic [1:0] J = 2'(j);
    assign row[j] = transpose ? m[{J, sel}] : m[{sel, J}];
  end
endmodule

// File: rtl/symm_row_serializer.sv
// symm_row_serializer: captures a 4x4 signed matrix and streams it one row per valid/ready beat.
// Optional SYMM_SER_TRANSPOSE_EN adds a transpose input that streams columns instead of rows.
module symm_row_serializer
  import fica_mat_pkg::*;
#(
  parameter int DW = DW_MAT,
  parameter int ROWS = 4
) (
  input  logic                 clk_ser,
  input  logic                 rst_ser,
  input  logic                 load,
  output logic                 load_rdy,
  input  logic                 dest_in,
`ifdef SYMM_SER_TRANSPOSE_EN
  input  logic                 transpose,
`endif
  input  logic signed [DW-1:0] i11, i12, i13, i14,
  input  logic signed [DW-1:0] i21, i22, i23, i24,
  input  logic signed [DW-1:0] i31, i32, i33, i34,
  input  logic signed [DW-1:0] i41, i42, i43, i44,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic signed [DW-1:0] r1, r2, r3, r4,
  output logic [1:0]           row_idx,
  output logic                 row_last,
  output logic                 row_dest,
  output logic                 done
);
  if (ROWS != 4) begin : g_rows_chk
    $fatal(1, "symm_row_serializer: ROWS must be 4");
  end
  ser_state_t state;
  logic [15:0][DW-1:0] m, in_m;
  logic [3:0][DW-1:0] nrow;
  logic tr, tr_in, acc;
  assign in_m = {i44, i43, i42, i41, i34, i33, i32, i31, i24, i23, i22, i21, i14, i13, i12, i11};
`ifdef SYMM_SER_TRANSPOSE_EN
  assign tr_in = transpose;
`else
  assign tr_in = 1'b0;
`endif
  assign load_rdy = state == IDLE && !rst_ser;
  assign acc = load && load_rdy;
  assign row_last = row_valid && row_idx == 2'd3;
  // On accept the first row comes straight from the inputs so it is visible the next cycle
  symm_row_mux #(.DW(DW)) u_mux (
    .m(acc ? in_m : m),
    .sel(acc ? 2'd0 : row_idx + 2'd1),
    .transpose(acc ? tr_in : tr),
    .row(nrow)
  );
  always_ff @(posedge clk_ser) begin
    if (rst_ser) begin
      state <= IDLE;
      row_valid <= 1'b0;
      done <= 1'b0;
      row_idx <= '0;
      row_dest <= 1'b0;
      m <= '0;
      tr <= 1'b0;
      {r4, r3, r2, r1} <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          m <= in_m;
          tr <= tr_in;
          row_dest <= dest_in;
          row_idx <= '0;
          row_valid <= 1'b1;
          {r4, r3, r2, r1} <= nrow;
          state <= SEND;
        end
        SEND: if (row_ready) begin
          if (row_idx == 2'd3) begin
            row_valid <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            row_idx <= row_idx + 2'd1;
            {r4, r3, r2, r1} <= nrow;
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_symm_row_serializer.sv
// tb_symm_row_serializer: directed table, corner sequences and random traffic against a row-queue model
module tb_symm_row_serializer;
  logic clk_ser = 1'b0, rst_ser, load, dest_in, transpose, row_ready;
  logic [15:0][25:0] mat;
  logic load_rdy, row_valid, row_last, row_dest, done;
  logic signed [25:0] r1, r2, r3, r4;
  logic [1:0] row_idx;
  int checks = 0, failures = 0;
  logic mon_en = 1'b0, pend = 1'b0;

  typedef struct {logic [103:0] d; logic [1:0] idx; logic dest;} beat_t;
  beat_t q[$];
  typedef struct {logic [15:0][25:0] m; logic dest; logic tr; logic [103:0] first; logic [103:0] last;} vec_t;
  vec_t vt[$];

  always #5 clk_ser = ~clk_ser;

  symm_row_serializer dut (
    .clk_ser(clk_ser), .rst_ser(rst_ser), .load(load), .load_rdy(load_rdy), .dest_in(dest_in),
`ifdef SYMM_SER_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .i11(mat[0]), .i12(mat[1]), .i13(mat[2]), .i14(mat[3]),
    .i21(mat[4]), .i22(mat[5]), .i23(mat[6]), .i24(mat[7]),
    .i31(mat[8]), .i32(mat[9]), .i33(mat[10]), .i34(mat[11]),
    .i41(mat[12]), .i42(mat[13]), .i43(mat[14]), .i44(mat[15]),
    .row_valid(row_valid), .row_ready(row_ready), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .row_idx(row_idx), .row_last(row_last), .row_dest(row_dest), .done(done)
  );

  task automatic chk(string nm, logic [103:0] got, logic [103:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [103:0] mk4(int a, int b, int c, int d);
    return {26'(a), 26'(b), 26'(c), 26'(d)};
  endfunction

  // Beat k of a matrix: row k, or column k when transposed; r1 ends up in the top bits
  function automatic logic [103:0] exp_row(logic [15:0][25:0] mm, logic t, int k);
    logic [103:0] res = '0;
    for (int c = 0; c < 4; c++) res = {res[77:0], t ? mm[c * 4 + k] : mm[k * 4 + c]};
    return res;
  endfunction

  function automatic logic [15:0][25:0] ten_rc();
    logic [15:0][25:0] mm;
    for (int r = 1; r <= 4; r++)
      for (int c = 1; c <= 4; c++) mm[(r - 1) * 4 + c - 1] = 26'(10 * r + c);
    return mm;
  endfunction

  function automatic logic [15:0][25:0] seq100();
    logic [15:0][25:0] mm;
    for (int k = 0; k < 16; k++) mm[k] = 26'(100 + k);
    return mm;
  endfunction

  function automatic logic [15:0][25:0] negs();
    logic [15:0][25:0] mm = '0;
    mm[0] = 26'h3FF_FFFF;
    mm[15] = 26'h200_0000;
    return mm;
  endfunction

  // Scoreboard: every accepted matrix becomes four expected beats; done follows the last one
  always @(posedge clk_ser) if (mon_en) begin
    chk("mon_valid", row_valid, q.size() != 0);
    chk("mon_load_rdy", load_rdy, !rst_ser && q.size() == 0 && !pend);
    chk("mon_done", done, pend);
    if (rst_ser) begin
      q.delete();
      pend <= 1'b0;
    end else begin
      pend <= row_valid && row_ready && q.size() != 0 && q[0].idx == 2'd3;
      if (row_valid && row_ready && q.size() != 0) begin
        chk("mon_row", {r1, r2, r3, r4}, q[0].d);
        chk("mon_idx", row_idx, q[0].idx);
        chk("mon_dest", row_dest, q[0].dest);
        chk("mon_last", row_last, q[0].idx == 2'd3);
        void'(q.pop_front());
      end
      if (load && load_rdy)
        for (int k = 0; k < 4; k++) q.push_back('{exp_row(mat, transpose, k), 2'(k), dest_in});
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk_ser);
      n++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk_ser);
  endtask

  task automatic start(logic [15:0][25:0] mm, logic d, logic t);
    mat = mm;
    dest_in = d;
    transpose = t;
    load = 1'b1;
    row_ready = 1'b1;
    chk("start_load_rdy", load_rdy, 1'b1);
    @(negedge clk_ser);
    load = 1'b0;
  endtask

  initial begin
    rst_ser = 1'b1; load = 1'b0; dest_in = 1'b0; transpose = 1'b0; row_ready = 1'b0; mat = '0;
    vt.push_back('{ten_rc(), 1'b1, 1'b0, mk4(11, 12, 13, 14), mk4(41, 42, 43, 44)});
    vt.push_back('{negs(), 1'b0, 1'b0, {26'h3FF_FFFF, 78'd0}, {78'd0, 26'h200_0000}});
    vt.push_back('{seq100(), 1'b0, 1'b0, mk4(100, 101, 102, 103), mk4(112, 113, 114, 115)});
`ifdef SYMM_SER_TRANSPOSE_EN
    vt.push_back('{ten_rc(), 1'b1, 1'b1, mk4(11, 21, 31, 41), mk4(14, 24, 34, 44)});
`endif
    repeat (3) @(posedge clk_ser);
    @(negedge clk_ser);
    chk("rst_valid", row_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", row_idx, 2'd0);
    chk("rst_dest", row_dest, 1'b0);
    chk("rst_rows", {r1, r2, r3, r4}, 104'd0);
    chk("rst_load_rdy", load_rdy, 1'b0);
    rst_ser = 1'b0;
    #1 chk("rel_load_rdy", load_rdy, 1'b1);
    mon_en = 1'b1;
    @(negedge clk_ser);
    foreach (vt[i]) begin
      start(vt[i].m, vt[i].dest, vt[i].tr);
      chk("tbl_first", {r1, r2, r3, r4}, vt[i].first);
      chk("tbl_idx0", row_idx, 2'd0);
      chk("tbl_last0", row_last, 1'b0);
      chk("tbl_dest", row_dest, vt[i].dest);
      repeat (3) @(negedge clk_ser);
      chk("tbl_final", {r1, r2, r3, r4}, vt[i].last);
      chk("tbl_last", row_last, 1'b1);
      chk("tbl_idx3", row_idx, 2'd3);
      @(negedge clk_ser);
      chk("tbl_done", done, 1'b1);
      chk("tbl_valid_off", row_valid, 1'b0);
      chk("tbl_busy", load_rdy, 1'b0);
      @(negedge clk_ser);
      chk("tbl_ready_again", load_rdy, 1'b1);
    end
    start(ten_rc(), 1'b1, 1'b0);
    @(negedge clk_ser);
    row_ready = 1'b0;
    mat = seq100();
    load = 1'b1;
    chk("bp_busy", load_rdy, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_ser);
      load = 1'b0;
      chk("bp_row", {r1, r2, r3, r4}, mk4(21, 22, 23, 24));
      chk("bp_idx", row_idx, 2'd1);
    end
    row_ready = 1'b1;
    @(negedge clk_ser);
    chk("bp_row2", {r1, r2, r3, r4}, mk4(31, 32, 33, 34));
    @(negedge clk_ser);
    chk("bp_row3", {r1, r2, r3, r4}, mk4(41, 42, 43, 44));
    wait_done();
    start(ten_rc(), 1'b0, 1'b0);
    repeat (2) @(negedge clk_ser);
    chk("ab_idx", row_idx, 2'd2);
    rst_ser = 1'b1;
    @(negedge clk_ser);
    rst_ser = 1'b0;
    chk("ab_valid", row_valid, 1'b0);
    chk("ab_done", done, 1'b0);
    @(negedge clk_ser);
    chk("ab_no_done", done, 1'b0);
    start(seq100(), 1'b1, 1'b0);
    chk("ab_new_row0", {r1, r2, r3, r4}, mk4(100, 101, 102, 103));
    chk("ab_new_idx", row_idx, 2'd0);
    wait_done();
    for (int n = 0; n < 3000; n++) begin
      row_ready = $urandom_range(0, 9) < 7;
      load = $urandom_range(0, 3) == 0;
      dest_in = 1'($urandom);
`ifdef SYMM_SER_TRANSPOSE_EN
      transpose = 1'($urandom);
`endif
      for (int k = 0; k < 16; k++) mat[k] = 26'($urandom);
      rst_ser = $urandom_range(0, 199) == 0;
      @(negedge clk_ser);
    end
    rst_ser = 1'b0;
    load = 1'b0;
    row_ready = 1'b1;
    repeat (10) @(negedge clk_ser);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
